decode_stage: RTL

//  Registered RV32I/M instruction-decode pipeline stage with a 2-entry elastic buffer and valid/ready handshakes on both sides.

---
 rtl/decode_stage_pkg.sv | 114 +++++++++++
 rtl/decode_stage_if.sv | 50 +++++
 rtl/decode_stage_comb.sv | 166 ++++++++++++++++
 rtl/decode_stage.sv | 133 +++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared opcode, immediate-select, ALU and SYSTEM encodings plus the decoded
// control bundle carried through the decode_stage buffer.
package decode_stage_pkg;

  typedef enum logic [6:0] {
    OPC_LOAD     = 7'b0000011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_OP_IMM   = 7'b0010011,
    OPC_AUIPC    = 7'b0010111,
    OPC_STORE    = 7'b0100011,
    OPC_OP       = 7'b0110011,
    OPC_LUI      = 7'b0110111,
    OPC_BRANCH   = 7'b1100011,
    OPC_JALR     = 7'b1100111,
    OPC_JAL      = 7'b1101111,
    OPC_SYSTEM   = 7'b1110011
  } opcode_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_sel_e;

  typedef enum logic [5:0] {
    ALU_ADD    = 6'd0,
    ALU_SUB    = 6'd1,
    ALU_SLL    = 6'd2,
    ALU_SLT    = 6'd3,
    ALU_SLTU   = 6'd4,
    ALU_XOR    = 6'd5,
    ALU_SRL    = 6'd6,
    ALU_SRA    = 6'd7,
    ALU_OR     = 6'd8,
    ALU_AND    = 6'd9,
    ALU_PASS_B = 6'd10,
    ALU_MUL    = 6'd16,
    ALU_MULH   = 6'd17,
    ALU_MULHSU = 6'd18,
    ALU_MULHU  = 6'd19,
    ALU_DIV    = 6'd20,
    ALU_DIVU   = 6'd21,
    ALU_REM    = 6'd22,
    ALU_REMU   = 6'd23
  } alu_op_e;

  typedef enum logic [2:0] {
    SYS_PRIV   = 3'b000,
    SYS_CSRRW  = 3'b001,
    SYS_CSRRS  = 3'b010,
    SYS_CSRRC  = 3'b011,
    SYS_RSVD   = 3'b100,
    SYS_CSRRWI = 3'b101,
    SYS_CSRRSI = 3'b110,
    SYS_CSRRCI = 3'b111
  } sys_f3_e;

  localparam logic [6:0]  FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0]  FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0]  FUNCT7_MULDIV = 7'b0000001;
  localparam logic [31:0] INSTR_ECALL   = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK  = 32'h0010_0073;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [2:0] funct3;
    alu_op_e    alu_op;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       branch;
    logic       jump;
    imm_sel_e   imm_sel;
    logic       is_ecall;
    logic       is_ebreak;
    logic       is_csr;
    logic       illegal;
  } ctrl_t;

  // alt selects SUB/SRA; callers only raise it where funct7[5] is meaningful.
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_from_f3 = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_from_f3 = ALU_SLL;
      3'b010:  alu_from_f3 = ALU_SLT;
      3'b011:  alu_from_f3 = ALU_SLTU;
      3'b100:  alu_from_f3 = ALU_XOR;
      3'b101:  alu_from_f3 = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_from_f3 = ALU_OR;
      default: alu_from_f3 = ALU_AND;
    endcase
  endfunction

  function automatic alu_op_e muldiv_from_f3(input logic [2:0] f3);
    case (f3)
      3'b000:  muldiv_from_f3 = ALU_MUL;
      3'b001:  muldiv_from_f3 = ALU_MULH;
      3'b010:  muldiv_from_f3 = ALU_MULHSU;
      3'b011:  muldiv_from_f3 = ALU_MULHU;
      3'b100:  muldiv_from_f3 = ALU_DIV;
      3'b101:  muldiv_from_f3 = ALU_DIVU;
      3'b110:  muldiv_from_f3 = ALU_REM;
      default: muldiv_from_f3 = ALU_REMU;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundles for decode_stage.
interface decode_in_if #(parameter int unsigned XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  modport master (output in_valid, in_instr, in_pc, input in_ready);
  modport slave  (input in_valid, in_instr, in_pc, output in_ready);
endinterface

interface decode_out_if #(parameter int unsigned XLEN = 32);
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imm;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [2:0]      out_funct3;
  logic [5:0]      out_alu_op;
  logic            out_alu_src_a;
  logic            out_alu_src_b;
  logic            out_mem_read;
  logic            out_mem_write;
  logic            out_mem_to_reg;
  logic            out_reg_write;
  logic            out_branch;
  logic            out_jump;
  logic [2:0]      out_imm_sel;
  logic            out_is_ecall;
  logic            out_is_ebreak;
  logic            out_is_csr;
  logic            out_illegal;

  modport master (
    output out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd, out_funct3,
           out_alu_op, out_alu_src_a, out_alu_src_b, out_mem_read, out_mem_write,
           out_mem_to_reg, out_reg_write, out_branch, out_jump, out_imm_sel,
           out_is_ecall, out_is_ebreak, out_is_csr, out_illegal,
    input  out_ready
  );
  modport slave (
    input  out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd, out_funct3,
           out_alu_op, out_alu_src_a, out_alu_src_b, out_mem_read, out_mem_write,
           out_mem_to_reg, out_reg_write, out_branch, out_jump, out_imm_sel,
           out_is_ecall, out_is_ebreak, out_is_csr, out_illegal,
    output out_ready
  );
endinterface

// File: rtl/decode_stage_comb.sv
// Purely combinational RV32I/M decoder: instruction -> control bundle + immediate.
// Optional CSR support is enabled by defining ZICSR_EN.
module decode_comb
  import decode_stage_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RV32E = 0,
  parameter int unsigned M_EXT = 1
) (
  input  logic [31:0]     instr,
  output ctrl_t           ctrl_o,
  output logic [XLEN-1:0] imm_o
);

  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rs1_f, rs2_f, rd_f;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
  logic        use_rs1, use_rs2, use_rd, keep_rs1, has_imm, csr_zext, bad;
  ctrl_t       c;

  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign rs1_f = instr[19:15];
  assign rs2_f = instr[24:20];
  assign rd_f  = instr[11:7];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    c        = '0;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    use_rd   = 1'b0;
    keep_rs1 = 1'b0;
    has_imm  = 1'b0;
    csr_zext = 1'b0;
    bad      = 1'b0;

    case (instr[6:0])
      OPC_LUI: begin
        use_rd = 1'b1; has_imm = 1'b1; c.imm_sel = IMM_U;
        c.alu_src_b = 1'b1; c.alu_op = ALU_PASS_B; c.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        use_rd = 1'b1; has_imm = 1'b1; c.imm_sel = IMM_U;
        c.alu_src_a = 1'b1; c.alu_src_b = 1'b1; c.alu_op = ALU_ADD; c.reg_write = 1'b1;
      end
      OPC_JAL: begin
        use_rd = 1'b1; has_imm = 1'b1; c.imm_sel = IMM_J;
        c.alu_src_a = 1'b1; c.alu_src_b = 1'b1; c.jump = 1'b1; c.reg_write = 1'b1;
      end
      OPC_JALR: begin
        use_rs1 = 1'b1; use_rd = 1'b1; has_imm = 1'b1; c.imm_sel = IMM_I;
        c.alu_src_b = 1'b1; c.jump = 1'b1; c.reg_write = 1'b1;
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; has_imm = 1'b1; c.imm_sel = IMM_B;
        c.branch = 1'b1;
        bad      = (f3 == 3'b010) || (f3 == 3'b011);
        case (f3[2:1])
          2'b10:   c.alu_op = ALU_SLT;
          2'b11:   c.alu_op = ALU_SLTU;
          default: c.alu_op = ALU_SUB;
        endcase
      end
      OPC_LOAD: begin
        use_rs1 = 1'b1; use_rd = 1'b1; has_imm = 1'b1; c.imm_sel = IMM_I;
        c.alu_src_b = 1'b1; c.mem_read = 1'b1; c.mem_to_reg = 1'b1; c.reg_write = 1'b1;
        bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; has_imm = 1'b1; c.imm_sel = IMM_S;
        c.alu_src_b = 1'b1; c.mem_write = 1'b1;
        bad = (f3 > 3'b010);
      end
      OPC_OP_IMM: begin
        use_rs1 = 1'b1; use_rd = 1'b1; has_imm = 1'b1; c.imm_sel = IMM_I;
        c.alu_src_b = 1'b1; c.reg_write = 1'b1;
        c.alu_op = alu_from_f3(f3, (f3 == 3'b101) && f7[5]);
        if (f3 == 3'b001) bad = (f7 != FUNCT7_BASE);
        if (f3 == 3'b101) bad = (f7 != FUNCT7_BASE) && (f7 != FUNCT7_ALT);
      end
      OPC_OP: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; c.reg_write = 1'b1;
        if (f7 == FUNCT7_BASE) begin
          c.alu_op = alu_from_f3(f3, 1'b0);
        end else if (f7 == FUNCT7_ALT) begin
          c.alu_op = alu_from_f3(f3, 1'b1);
          bad      = (f3 != 3'b000) && (f3 != 3'b101);
        end else if ((f7 == FUNCT7_MULDIV) && (M_EXT != 0)) begin
          c.alu_op = muldiv_from_f3(f3);
        end else begin
          bad = 1'b1;
        end
      end
      OPC_MISC_MEM: begin
        has_imm = 1'b1; c.imm_sel = IMM_I;
      end
      OPC_SYSTEM: begin
        case (f3)
          SYS_PRIV: begin
            c.is_ecall  = (instr == INSTR_ECALL);
            c.is_ebreak = (instr == INSTR_EBREAK);
            bad         = !(c.is_ecall || c.is_ebreak);
          end
          SYS_RSVD: bad = 1'b1;
          default: begin
`ifdef ZICSR_EN
            // Immediate forms reuse the rs1 field as zimm, so it is passed on
            // but not treated as a register index.
            use_rd   = 1'b1; keep_rs1 = 1'b1; use_rs1 = !f3[2];
            has_imm  = 1'b1; csr_zext = 1'b1; c.imm_sel = IMM_I;
            c.is_csr = 1'b1; c.reg_write = (rd_f != 5'd0);
`else
            bad = 1'b1;
`endif
          end
        endcase
      end
      default: bad = 1'b1;
    endcase

    c.rs1    = (use_rs1 || keep_rs1) ? rs1_f : 5'd0;
    c.rs2    = use_rs2 ? rs2_f : 5'd0;
    c.rd     = use_rd  ? rd_f  : 5'd0;
    c.funct3 = f3;

    if (RV32E != 0)
      bad = bad || (use_rs1 && rs1_f[4]) || (use_rs2 && rs2_f[4]) || (use_rd && rd_f[4]);

    if (bad) begin
      c.illegal    = 1'b1;
      c.reg_write  = 1'b0;
      c.mem_read   = 1'b0;
      c.mem_write  = 1'b0;
      c.mem_to_reg = 1'b0;
      c.branch     = 1'b0;
      c.jump       = 1'b0;
      c.is_ecall   = 1'b0;
      c.is_ebreak  = 1'b0;
      c.is_csr     = 1'b0;
    end

    imm32 = '0;
    if (has_imm) begin
      case (c.imm_sel)
        IMM_S:   imm32 = imm_s;
        IMM_B:   imm32 = imm_b;
        IMM_U:   imm32 = imm_u;
        IMM_J:   imm32 = imm_j;
        default: imm32 = imm_i;
      endcase
    end

    if (csr_zext) imm_o = XLEN'(instr[31:20]);
    else          imm_o = XLEN'($signed(imm32));

    ctrl_o = c;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decodes on the input side, then holds results in a
// 2-entry FIFO with valid/ready handshakes. Optional CSR decode via ZICSR_EN.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RV32E = 0,
  parameter int unsigned M_EXT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  decode_in_if.slave   in_if,
  decode_out_if.master out_if
);

  ctrl_t           dec_ctrl;
  logic [XLEN-1:0] dec_imm;

  logic [1:0]      count_q, count_d;
  ctrl_t           ctrl_q [2];
  ctrl_t           ctrl_d [2];
  logic [XLEN-1:0] pc_q   [2];
  logic [XLEN-1:0] pc_d   [2];
  logic [XLEN-1:0] imm_q  [2];
  logic [XLEN-1:0] imm_d  [2];

  logic            in_ready, out_valid, accept, pop;
  ctrl_t           head_ctrl;
  logic [XLEN-1:0] head_pc, head_imm;

  decode_comb #(
    .XLEN  (XLEN),
    .RV32E (RV32E),
    .M_EXT (M_EXT)
  ) u_decode_comb (
    .instr  (in_if.in_instr),
    .ctrl_o (dec_ctrl),
    .imm_o  (dec_imm)
  );

  assign in_ready       = !rst && (count_q != 2'd2);
  assign out_valid      = (count_q != 2'd0);
  assign accept         = in_if.in_valid && in_ready;
  assign pop            = out_valid && out_if.out_ready;
  assign in_if.in_ready = in_ready;

  always_comb begin
    count_d = count_q;
    for (int unsigned i = 0; i < 2; i++) begin
      ctrl_d[i] = ctrl_q[i];
      pc_d[i]   = pc_q[i];
      imm_d[i]  = imm_q[i];
    end

    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({accept, pop})
        2'b10: begin
          // Fill the first free slot: slot 0 when empty, otherwise slot 1.
          if (count_q == 2'd0) begin
            ctrl_d[0] = dec_ctrl; pc_d[0] = in_if.in_pc; imm_d[0] = dec_imm;
          end else begin
            ctrl_d[1] = dec_ctrl; pc_d[1] = in_if.in_pc; imm_d[1] = dec_imm;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          ctrl_d[0] = ctrl_q[1]; pc_d[0] = pc_q[1]; imm_d[0] = imm_q[1];
          count_d   = count_q - 2'd1;
        end
        2'b11: begin
          // Accept+pop only occurs at count 1 (count 2 blocks accept).
          ctrl_d[0] = dec_ctrl; pc_d[0] = in_if.in_pc; imm_d[0] = dec_imm;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        ctrl_q[i] <= '0;
        pc_q[i]   <= '0;
        imm_q[i]  <= '0;
      end
    end else begin
      count_q <= count_d;
      for (int unsigned i = 0; i < 2; i++) begin
        ctrl_q[i] <= ctrl_d[i];
        pc_q[i]   <= pc_d[i];
        imm_q[i]  <= imm_d[i];
      end
    end
  end

  always_comb begin
    head_ctrl = ctrl_q[0];
    head_pc   = pc_q[0];
    head_imm  = imm_q[0];
    if (!out_valid) begin
      head_ctrl = '0;
      head_pc   = '0;
      head_imm  = '0;
    end
  end

  assign out_if.out_valid      = out_valid;
  assign out_if.out_pc         = head_pc;
  assign out_if.out_imm        = head_imm;
  assign out_if.out_rs1        = head_ctrl.rs1;
  assign out_if.out_rs2        = head_ctrl.rs2;
  assign out_if.out_rd         = head_ctrl.rd;
  assign out_if.out_funct3     = head_ctrl.funct3;
  assign out_if.out_alu_op     = head_ctrl.alu_op;
  assign out_if.out_alu_src_a  = head_ctrl.alu_src_a;
  assign out_if.out_alu_src_b  = head_ctrl.alu_src_b;
  assign out_if.out_mem_read   = head_ctrl.mem_read;
  assign out_if.out_mem_write  = head_ctrl.mem_write;
  assign out_if.out_mem_to_reg = head_ctrl.mem_to_reg;
  assign out_if.out_reg_write  = head_ctrl.reg_write;
  assign out_if.out_branch     = head_ctrl.branch;
  assign out_if.out_jump       = head_ctrl.jump;
  assign out_if.out_imm_sel    = head_ctrl.imm_sel;
  assign out_if.out_is_ecall   = head_ctrl.is_ecall;
  assign out_if.out_is_ebreak  = head_ctrl.is_ebreak;
  assign out_if.out_is_csr     = head_ctrl.is_csr;
  assign out_if.out_illegal    = head_ctrl.illegal;

endmodule
